// File: rtl/ydemux_pkg.sv
// Shared defaults and helpers for the buffered 1-to-2 stream demultiplexer.
package ydemux_pkg;

  localparam int YDEMUX_W     = 2;
  localparam int YDEMUX_DEPTH = 2;
  localparam int YDEMUX_CW    = 8;

  // Pointer width for a power-of-two FIFO depth (depth >= 2).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ydemux_fifo.sv
// Single W x DEPTH FIFO with occupancy counter; head word is presented combinationally
// from storage, and storage is cleared on reset so the head reads 0 afterwards.
module ydemux_fifo
  import ydemux_pkg::*;
#(
  parameter int W     = YDEMUX_W,
  parameter int DEPTH = YDEMUX_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (PW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/ydemux2_buf.sv
// Buffered 1-to-2 stream demultiplexer: in_sel routes each word into one of two FIFOs.
// Optional per-output transfer counters cnt0/cnt1 are built when YDEMUX2_BUF_STATS_EN is defined.
module ydemux2_buf
  import ydemux_pkg::*;
#(
  parameter int W     = YDEMUX_W,
  parameter int DEPTH = YDEMUX_DEPTH,
  parameter int CW    = YDEMUX_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [W-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready
`ifdef YDEMUX2_BUF_STATS_EN
  ,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CW < 1) begin : g_param_chk
    $error("ydemux2_buf: DEPTH must be a power of two >= 2 and CW >= 1");
  end

  logic full0, full1;
  logic empty0, empty1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // in_ready depends only on the addressed FIFO, never on in_valid or the consumers.
  assign in_ready   = in_sel ? !full1 : !full0;
  assign accept     = in_valid && in_ready;
  assign push0      = accept && !in_sel;
  assign push1      = accept &&  in_sel;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  ydemux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data),
    .rdata (out0_data),
    .full  (full0),
    .empty (empty0)
  );

  ydemux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data),
    .rdata (out1_data),
    .full  (full1),
    .empty (empty1)
  );

`ifdef YDEMUX2_BUF_STATS_EN
  // Free-running transfer counters; wrap modulo 2^CW.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ydemux2_buf.sv
// Scoreboard bench for ydemux2_buf: per-output expected-word queues, directed cases then random traffic.
module tb_ydemux2_buf;

  localparam int W     = 2;
  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
`ifdef YDEMUX2_BUF_STATS_EN
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
`endif

  always #5 clk = ~clk;

  ydemux2_buf #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef YDEMUX2_BUF_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  int            n_vec  = 0;
  int            n_fail = 0;
  logic          mon_en = 1'b0;
  logic [W-1:0]  q0[$];
  logic [W-1:0]  q1[$];
  logic [CW-1:0] cm0 = '0;
  logic [CW-1:0] cm1 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: model state reflects every edge so far; pops model on handshakes taken at the coming edge.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      q0.delete();
      q1.delete();
      cm0 = '0;
      cm1 = '0;
    end else if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'((in_sel ? q1.size() : q0.size()) < DEPTH));
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
`ifdef YDEMUX2_BUF_STATS_EN
      chk("cnt0", 32'(cnt0), 32'(cm0));
      chk("cnt1", 32'(cnt1), 32'(cm1));
`endif
      if (q0.size() != 0) begin
        chk("out0_data", 32'(out0_data), 32'(q0[0]));
        if (out0_ready) begin
          void'(q0.pop_front());
          cm0 = cm0 + 1'b1;
        end
      end
      if (q1.size() != 0) begin
        chk("out1_data", 32'(out1_data), 32'(q1[0]));
        if (out1_ready) begin
          void'(q1.pop_front());
          cm1 = cm1 + 1'b1;
        end
      end
    end
  end

  // One clock of stimulus; an accepted word is pushed onto the expected queue of its output.
  task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1, input logic rs, output logic acc);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    reset      = rs;
    #3;
    acc = v && in_ready && !rs;
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic acc;
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
    mon_en = 1'b1;

    // Single route
    cycle(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, acc);
    chk("route0_acc", 32'(acc), 32'd1);
    cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, acc);
    chk("route1_acc", 32'(acc), 32'd1);
    idle(3);

    // Exhaustive sweep of data x sel
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 4; d++) begin
        cycle(1'b1, 1'(s), W'(d), 1'b1, 1'b1, 1'b0, acc);
        chk("sweep_acc", 32'(acc), 32'd1);
        idle(1);
      end

    // Backpressure on output 1
    idle(2);
    cycle(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    cycle(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_acc2", 32'(acc), 32'd1);
    cycle(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_full", 32'(acc), 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_other", 32'(acc), 32'd1);
    cycle(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, acc);
    chk("bp_nobypass", 32'(acc), 32'd0);
    cycle(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, acc);
    chk("bp_resume", 32'(acc), 32'd1);
    idle(4);

    // Simultaneous push and pop on FIFO 0
    cycle(1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, acc);
    chk("pp_first", 32'(acc), 32'd1);
    cycle(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, acc);
    chk("pp_both", 32'(acc), 32'd1);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, acc);
    idle(2);

    // Reset mid-stream with both FIFOs full
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0; in_sel = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1; reset = 1'b0;
    #2;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("rst_ready_sel1", 32'(in_ready), 32'd1);
`ifdef YDEMUX2_BUF_STATS_EN
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
`endif
    idle(3);

    // Long run on output 0 so the transfer counter wraps
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 1'b0, W'($urandom), 1'b1, 1'b1, 1'b0, acc);
    idle(2);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), W'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 79) == 0, acc);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
